// File: rtl/data_cache_dm.sv
// Direct-mapped line cache with a blocking miss path and one outstanding fill.
// Optional hit/miss statistics are built when DCACHE_STATS_EN is defined.
module data_cache_dm #(
  parameter int DATAW    = 16,
  parameter int LINEW    = 512,
  parameter int ADDRW    = 32,
  parameter int NUMLINES = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_ready,
  input  logic              rd_req,
  input  logic [ADDRW-1:0]  rd_addr,
  input  logic              wr_en,
  input  logic [ADDRW-1:0]  wr_addr,
  input  logic [LINEW-1:0]  wr_data,
  input  logic              flush,
  output logic              rd_valid,
  output logic              rd_hit,
  output logic [LINEW-1:0]  rd_data,
  output logic              mem_req,
  output logic [ADDRW-1:0]  mem_addr,
  input  logic              mem_valid,
  input  logic [LINEW-1:0]  mem_data,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int IDXW = $clog2(NUMLINES);
  localparam int TAGW = ADDRW - IDXW;

  if ((LINEW % DATAW) != 0 || NUMLINES < 2 || (1 << IDXW) != NUMLINES) begin : g_bad_params
    $error("data_cache_dm: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

  state_t              state_q, state_d;
  logic [NUMLINES-1:0] valid_q, valid_d;
  logic [ADDRW-1:0]    addr_q, addr_d;
  logic [ADDRW-1:0]    mem_addr_q, mem_addr_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_hit_q, rd_hit_d;
  logic [LINEW-1:0]    rd_data_q, rd_data_d;
  logic                mem_req_q, mem_req_d;
  logic                flush_pend_q, flush_pend_d;

  logic [LINEW-1:0]    line_mem [NUMLINES];
  logic [TAGW-1:0]     tag_mem  [NUMLINES];

  logic                line_we;
  logic [IDXW-1:0]     line_idx;
  logic [TAGW-1:0]     line_tag;
  logic [LINEW-1:0]    line_wdata;
  logic                lookup_hit;
  logic                same_line;

  logic [IDXW-1:0]     rd_idx, wr_idx, fill_idx;
  logic [TAGW-1:0]     rd_tag, wr_tag, fill_tag;

  assign rd_idx    = rd_addr[IDXW-1:0];
  assign rd_tag    = rd_addr[ADDRW-1:IDXW];
  assign wr_idx    = wr_addr[IDXW-1:0];
  assign wr_tag    = wr_addr[ADDRW-1:IDXW];
  assign fill_idx  = addr_q[IDXW-1:0];
  assign fill_tag  = addr_q[ADDRW-1:IDXW];
  assign same_line = wr_en && (wr_idx == rd_idx);

  // The tag compare happens at acceptance against the post-write/post-flush view,
  // so the response flops are already loaded while the FSM sits in LOOKUP.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    mem_addr_d   = mem_addr_q;
    rd_valid_d   = 1'b0;
    rd_hit_d     = rd_hit_q;
    rd_data_d    = rd_data_q;
    mem_req_d    = mem_req_q;
    flush_pend_d = flush_pend_q;
    line_we      = 1'b0;
    line_idx     = wr_idx;
    line_tag     = wr_tag;
    line_wdata   = wr_data;
    lookup_hit   = 1'b0;

    if (flush) valid_d = '0;

    case (state_q)
      IDLE: begin
        flush_pend_d = 1'b0;
        if (wr_en) begin
          line_we         = 1'b1;
          valid_d[wr_idx] = 1'b1;
        end
        if (rd_req) begin
          addr_d  = rd_addr;
          state_d = LOOKUP;
          if (same_line) lookup_hit = (wr_tag == rd_tag);
          else           lookup_hit = valid_d[rd_idx] && (tag_mem[rd_idx] == rd_tag);
          rd_hit_d = lookup_hit;
          if (lookup_hit) begin
            rd_valid_d = 1'b1;
            rd_data_d  = same_line ? wr_data : line_mem[rd_idx];
          end
        end
      end
      LOOKUP: begin
        flush_pend_d = flush_pend_q | flush;
        if (rd_hit_q) begin
          state_d = IDLE;
        end else begin
          state_d    = FILL;
          mem_req_d  = 1'b1;
          mem_addr_d = addr_q;
        end
      end
      FILL: begin
        flush_pend_d = flush_pend_q | flush;
        if (mem_valid) begin
          line_we    = 1'b1;
          line_idx   = fill_idx;
          line_tag   = fill_tag;
          line_wdata = mem_data;
          // A flush seen at any point during the miss leaves the filled line invalid.
          if (!(flush || flush_pend_q)) valid_d[fill_idx] = 1'b1;
          mem_req_d  = 1'b0;
          rd_valid_d = 1'b1;
          rd_hit_d   = 1'b0;
          rd_data_d  = mem_data;
          state_d    = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_hit_q     <= 1'b0;
      rd_data_q    <= '0;
      mem_req_q    <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      mem_addr_q   <= mem_addr_d;
      rd_valid_q   <= rd_valid_d;
      rd_hit_q     <= rd_hit_d;
      rd_data_q    <= rd_data_d;
      mem_req_q    <= mem_req_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      line_mem[line_idx] <= line_wdata;
      tag_mem[line_idx]  <= line_tag;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rd_valid  = rd_valid_q;
  assign rd_hit    = rd_hit_q;
  assign rd_data   = rd_data_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (req_ready && rd_req) begin
      if (lookup_hit) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_data_cache_dm.sv
// Randomized bench for data_cache_dm against an address-keyed line model.
module tb_data_cache_dm;
  localparam int LINEW = 512;
  localparam int ADDRW = 32;
  localparam int NL    = 8;

  typedef logic [LINEW-1:0] line_t;
  typedef logic [ADDRW-1:0] addr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_ready;
  logic        rd_req = 1'b0;
  addr_t       rd_addr = '0;
  logic        wr_en = 1'b0;
  addr_t       wr_addr = '0;
  line_t       wr_data = '0;
  logic        flush = 1'b0;
  logic        rd_valid;
  logic        rd_hit;
  line_t       rd_data;
  logic        mem_req;
  addr_t       mem_addr;
  logic        mem_valid = 1'b0;
  line_t       mem_data = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  data_cache_dm dut (
    .clk(clk), .rst(rst), .req_ready(req_ready),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush),
    .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_data(rd_data),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: each slot remembers which full line address it holds.
  bit    m_valid [NL];
  addr_t m_addr  [NL];
  line_t m_data  [NL];
  int    exp_hits   = 0;
  int    exp_misses = 0;

  task automatic chk(input string tag, input line_t got, input line_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic line_t rand_line();
    line_t r;
    for (int i = 0; i < LINEW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic int slot(input addr_t a);
    return int'(a % NL);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_write(input addr_t a, input line_t d);
    m_valid[slot(a)] = 1'b1;
    m_addr[slot(a)]  = a;
    m_data[slot(a)]  = d;
  endtask

  function automatic bit model_hit(input addr_t a);
    return m_valid[slot(a)] && (m_addr[slot(a)] == a);
  endfunction

  task automatic check_stats();
`ifdef DCACHE_STATS_EN
    chk("hit_count", line_t'(hit_count), line_t'(exp_hits));
    chk("miss_count", line_t'(miss_count), line_t'(exp_misses));
`else
    chk("hit_count_off", line_t'(hit_count), '0);
    chk("miss_count_off", line_t'(miss_count), '0);
`endif
  endtask

  task automatic do_write(input addr_t a, input line_t d, input bit fl);
    @(negedge clk);
    chk("wr_ready", line_t'(req_ready), line_t'(1'b1));
    wr_en = 1'b1; wr_addr = a; wr_data = d; flush = fl;
    mem_valid = 1'($urandom % 2); mem_data = rand_line();
    @(negedge clk);
    wr_en = 1'b0; flush = 1'b0; mem_valid = 1'b0;
    if (fl) model_clear();
    model_write(a, d);
    chk("wr_no_resp", line_t'(rd_valid), '0);
    chk("wr_no_memreq", line_t'(mem_req), '0);
  endtask

  // fcyc: FILL cycle on which flush pulses (dly means together with mem_valid), -1 for none.
  task automatic do_read(input addr_t a, input bit wr, input addr_t wa, input line_t wd,
                         input int dly, input int fcyc, input line_t fd);
    bit    exp_hit;
    line_t exp_d;
    @(negedge clk);
    chk("rd_ready", line_t'(req_ready), line_t'(1'b1));
    rd_req = 1'b1; rd_addr = a; wr_en = wr; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    rd_req = 1'b0; wr_en = 1'b0;
    if (wr) model_write(wa, wd);
    exp_hit = model_hit(a);
    chk("busy_not_ready", line_t'(req_ready), '0);
    chk("lookup_valid", line_t'(rd_valid), line_t'(exp_hit));
    chk("lookup_memreq", line_t'(mem_req), '0);
    if (exp_hit) begin
      exp_hits++;
      exp_d = m_data[slot(a)];
      chk("hit_flag", line_t'(rd_hit), line_t'(1'b1));
      chk("hit_data", rd_data, exp_d);
      @(negedge clk);
      chk("post_hit_valid", line_t'(rd_valid), '0);
      chk("post_hit_ready", line_t'(req_ready), line_t'(1'b1));
      chk("post_hit_memreq", line_t'(mem_req), '0);
      chk("hold_data", rd_data, exp_d);
    end else begin
      exp_misses++;
      @(negedge clk);
      for (int i = 0; i < dly; i++) begin
        chk("fill_req_held", line_t'(mem_req), line_t'(1'b1));
        flush = (i == fcyc);
        rd_req = 1'($urandom % 2); rd_addr = addr_t'($urandom % 24);
        wr_en = 1'($urandom % 2); wr_addr = addr_t'($urandom % 24); wr_data = rand_line();
        @(negedge clk);
        flush = 1'b0;
      end
      chk("fill_req", line_t'(mem_req), line_t'(1'b1));
      chk("fill_addr", line_t'(mem_addr), line_t'(a));
      mem_valid = 1'b1; mem_data = fd; flush = (fcyc == dly);
      @(negedge clk);
      mem_valid = 1'b0; flush = 1'b0; rd_req = 1'b0; wr_en = 1'b0;
      mem_data = rand_line();
      if (fcyc >= 0) model_clear();
      else model_write(a, fd);
      chk("resp_valid", line_t'(rd_valid), line_t'(1'b1));
      chk("resp_hit", line_t'(rd_hit), '0);
      chk("resp_data", rd_data, fd);
      chk("resp_memreq", line_t'(mem_req), '0);
      @(negedge clk);
      chk("post_resp_valid", line_t'(rd_valid), '0);
      chk("post_resp_ready", line_t'(req_ready), line_t'(1'b1));
      chk("hold_fill_data", rd_data, fd);
    end
  endtask

  initial begin
    line_t d;
    model_clear();
    #1;
    chk("rst_ready", line_t'(req_ready), line_t'(1'b1));
    chk("rst_rd_valid", line_t'(rd_valid), '0);
    chk("rst_rd_hit", line_t'(rd_hit), '0);
    chk("rst_rd_data", rd_data, '0);
    chk("rst_mem_req", line_t'(mem_req), '0);
    chk("rst_mem_addr", line_t'(mem_addr), '0);
    check_stats();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // cold miss, then re-read hits
    d = {(LINEW/8){8'hA5}};
    do_read(32'h10, 1'b0, '0, '0, 3, -1, d);
    do_read(32'h10, 1'b0, '0, '0, 0, -1, '0);
    check_stats();

    // conflict on index 0
    do_read(32'h18, 1'b0, '0, '0, 1, -1, rand_line());
    do_read(32'h10, 1'b0, '0, '0, 2, -1, rand_line());

    // same-cycle write and read
    d = rand_line();
    do_read(32'h05, 1'b1, 32'h05, d, 0, -1, '0);

    // flush mid-fill, and flush together with mem_valid
    d = rand_line();
    do_read(32'h23, 1'b0, '0, '0, 2, 1, d);
    do_read(32'h23, 1'b0, '0, '0, 1, 1, rand_line());
    do_read(32'h23, 1'b0, '0, '0, 0, -1, rand_line());
    do_read(32'h23, 1'b0, '0, '0, 0, -1, '0);

    // flush with write keeps only the written line
    do_write(32'h0A, rand_line(), 1'b0);
    do_write(32'h31, rand_line(), 1'b1);
    do_read(32'h31, 1'b0, '0, '0, 0, -1, '0);
    do_read(32'h0A, 1'b0, '0, '0, 1, -1, rand_line());
    check_stats();

    // reset during FILL
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 32'h44;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_mem_req", line_t'(mem_req), line_t'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_mem_req", line_t'(mem_req), '0);
    chk("async_rst_ready", line_t'(req_ready), line_t'(1'b1));
    chk("async_rst_rd_data", rd_data, '0);
    model_clear();
    exp_hits = 0; exp_misses = 0;
    check_stats();
    @(negedge clk);
    rst = 1'b0; mem_valid = 1'b1; mem_data = rand_line();
    @(negedge clk);
    mem_valid = 1'b0;
    chk("late_mv_ready", line_t'(req_ready), line_t'(1'b1));
    chk("late_mv_valid", line_t'(rd_valid), '0);
    chk("late_mv_memreq", line_t'(mem_req), '0);
    do_read(32'h44, 1'b0, '0, '0, 1, -1, rand_line());
    do_read(32'h44, 1'b0, '0, '0, 0, -1, '0);
    check_stats();

    for (int it = 0; it < 80; it++) begin
      int    op;
      int    dly;
      int    fc;
      addr_t a;
      addr_t wa;
      op = int'($urandom % 4);
      a  = addr_t'($urandom % 24);
      if (op == 0) begin
        do_write(a, rand_line(), ($urandom % 4) == 0);
      end else if (op == 3 && ($urandom % 2) == 0) begin
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
      end else begin
        dly = int'($urandom % 4);
        fc  = (($urandom % 4) == 0) ? int'($urandom_range(0, dly)) : -1;
        wa  = (($urandom % 2) == 0) ? a : addr_t'($urandom % 24);
        do_read(a, ($urandom % 3) == 0, wa, rand_line(), dly, fc, rand_line());
      end
      if (it % 10 == 9) check_stats();
    end
    check_stats();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
